// File: rtl/csr_counters_pkg.sv
// ----------------------------------------------------------------------------
// csr_counters_pkg
// Shared types and constants for the machine-mode counter/timer CSR block:
//   - csr_reg_addr_t / csr_op_t as produced by CSR decode
//   - privilege encodings and the CSR addresses this block serves
//   - bit indices of mcounteren / mcountinhibit and their packed layout
//   - csr_apply_op(): RW/RS/RC write-value computation
// ----------------------------------------------------------------------------
package csr_counters_pkg;

    typedef logic [11:0] csr_reg_addr_t;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_t;

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_M = 2'b11;

    localparam int COUNTEREN_CY = 0;
    localparam int COUNTEREN_TM = 1;
    localparam int COUNTEREN_IR = 2;
    localparam int INHIBIT_CY   = 0;
    localparam int INHIBIT_IR   = 2;

    localparam csr_reg_addr_t CSR_MCYCLE        = 12'hB00;
    localparam csr_reg_addr_t CSR_MINSTRET      = 12'hB02;
    localparam csr_reg_addr_t CSR_MHPMCOUNTER3  = 12'hB03;
    localparam csr_reg_addr_t CSR_MCYCLEH       = 12'hB80;
    localparam csr_reg_addr_t CSR_MINSTRETH     = 12'hB82;
    localparam csr_reg_addr_t CSR_MCOUNTEREN    = 12'h306;
    localparam csr_reg_addr_t CSR_MCOUNTINHIBIT = 12'h320;
    localparam csr_reg_addr_t CSR_MHPMEVENT3    = 12'h323;
    localparam csr_reg_addr_t CSR_CYCLE         = 12'hC00;
    localparam csr_reg_addr_t CSR_TIME          = 12'hC01;
    localparam csr_reg_addr_t CSR_INSTRET       = 12'hC02;
    localparam csr_reg_addr_t CSR_TIMEH         = 12'hC81;

    // Shared layout of mcounteren and mcountinhibit (tm is always 0 in
    // mcountinhibit; hpm bits are hardwired to 0 in both).
    typedef struct packed {
        logic [28:0] hpm;
        logic        ir;
        logic        tm;
        logic        cy;
    } cnt_ctrl_t;

    function automatic logic [31:0] csr_apply_op(input csr_op_t op,
                                                 input logic [31:0] old_val,
                                                 input logic [31:0] wdata);
        logic [31:0] res;
        case (op)
            CSR_OP_RW: res = wdata;
            CSR_OP_RS: res = old_val | wdata;
            CSR_OP_RC: res = old_val & ~wdata;
            default:   res = old_val;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/csr_counters_if.sv
// ----------------------------------------------------------------------------
// csr_counters_if
// CSR access request/response bundle between CSR decode (master) and the
// counter block (slave).
//   request : csr_req, csr_addr, csr_op, csr_wdata, csr_rs1_zero, csr_priv
//   response: rsp_valid, rsp_hit, rsp_illegal, rsp_rdata
// ----------------------------------------------------------------------------
interface csr_counters_if;
    import csr_counters_pkg::*;

    logic          csr_req;
    csr_reg_addr_t csr_addr;
    csr_op_t       csr_op;
    logic [31:0]   csr_wdata;
    logic          csr_rs1_zero;
    logic [1:0]    csr_priv;

    logic          rsp_valid;
    logic          rsp_hit;
    logic          rsp_illegal;
    logic [31:0]   rsp_rdata;

    modport master (
        output csr_req, csr_addr, csr_op, csr_wdata, csr_rs1_zero, csr_priv,
        input  rsp_valid, rsp_hit, rsp_illegal, rsp_rdata
    );

    modport slave (
        input  csr_req, csr_addr, csr_op, csr_wdata, csr_rs1_zero, csr_priv,
        output rsp_valid, rsp_hit, rsp_illegal, rsp_rdata
    );
endinterface

// File: rtl/csr_counters_counter64.sv
// ----------------------------------------------------------------------------
// csr_counters_counter64
// 64-bit free-running counter with 32-bit half writes.
//   clk, rst : clock, asynchronous active-high reset (loads RST_VAL)
//   inc      : amount added each cycle
//   inhibit  : hold the count
//   wr_lo    : load wdata into bits 31:0
//   wr_hi    : load wdata into bits 63:32
//   wdata    : write data
//   value    : current count
// A write to either half wins over the increment for that cycle; the other
// half keeps its value with no carry applied.
// ----------------------------------------------------------------------------
module csr_counters_counter64 #(
    parameter int          INC_W   = 1,
    parameter logic [63:0] RST_VAL = 64'h0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [INC_W-1:0] inc,
    input  logic             inhibit,
    input  logic             wr_lo,
    input  logic             wr_hi,
    input  logic [31:0]      wdata,
    output logic [63:0]      value
);
    logic [63:0] value_reg;
    logic [63:0] value_next;

    always_comb begin
        value_next = value_reg;
        if (wr_lo) begin
            value_next[31:0] = wdata;
        end else if (wr_hi) begin
            value_next[63:32] = wdata;
        end else if (!inhibit) begin
            // Single 64-bit add so the low-half carry lands in the same cycle.
            value_next = value_reg + 64'(inc);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_reg <= RST_VAL;
        end else begin
            value_reg <= value_next;
        end
    end

    assign value = value_reg;
endmodule

// File: rtl/csr_counters.sv
// ----------------------------------------------------------------------------
// csr_counters
// Machine-mode counter/timer CSRs: mcycle/minstret (64-bit, 32-bit halves),
// mcountinhibit, mcounteren, unprivileged CYCLE/TIME/INSTRET(H) shadows and
// the hardwired-zero HPM counter/event range.
//   clk, rst     : clock, asynchronous active-high reset
//   bus          : CSR request/response (slave side); the response is
//                  registered and appears exactly one cycle after csr_req
//   retire_count : instructions retired this cycle
//   mtime        : platform timer, read through TIME/TIMEH
// rsp_rdata is the CSR value in the request cycle, before that cycle's write
// and counter increment. Misses and illegal accesses return 0.
// ----------------------------------------------------------------------------
module csr_counters
    import csr_counters_pkg::*;
#(
    parameter int          RETIRE_PORTS = 2,
    parameter logic [63:0] MCYCLE_RST   = 64'h0,
    parameter logic [63:0] MINSTRET_RST = 64'h0,
    localparam int         RETIRE_W     = $clog2(RETIRE_PORTS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    csr_counters_if.slave       bus,
    input  logic [RETIRE_W-1:0] retire_count,
    input  logic [63:0]         mtime
);
    csr_reg_addr_t addr;
    logic [4:0]    idx;

    logic in_mcnt_lo, in_mcnt_hi, in_mcnt, in_ucnt;
    logic in_evt, is_inhibit, is_counteren, hit;
    logic wr_intent, illegal, do_write;
    logic [31:0] counteren_word;
    logic [63:0] cnt_sel;
    logic [31:0] rd_val;
    logic [31:0] wr_val;

    logic [63:0] mcycle, minstret;
    cnt_ctrl_t   inhibit_reg, inhibit_next;
    cnt_ctrl_t   counteren_reg, counteren_next;

    logic        rsp_valid_reg, rsp_hit_reg, rsp_illegal_reg;
    logic [31:0] rsp_rdata_reg;

    assign addr = bus.csr_addr;
    assign idx  = addr[4:0];

    // ---------------- address decode ----------------
    always_comb begin
        // B00-B1F / B80-B9F, minus the nonexistent B01/B81 (mtime is not a CSR)
        in_mcnt_lo   = (addr[11:5] == 7'h58) && (idx != 5'd1);
        in_mcnt_hi   = (addr[11:5] == 7'h5C) && (idx != 5'd1);
        in_mcnt      = in_mcnt_lo || in_mcnt_hi;
        // C00-C1F / C80-C9F
        in_ucnt      = (addr[11:5] == 7'h60) || (addr[11:5] == 7'h64);
        // 323-33F / 723-73F
        in_evt       = ((addr[11:5] == 7'h19) || (addr[11:5] == 7'h39)) && (idx >= 5'd3);
        is_inhibit   = (addr == CSR_MCOUNTINHIBIT);
        is_counteren = (addr == CSR_MCOUNTEREN);
        hit          = in_mcnt || in_ucnt || in_evt || is_inhibit || is_counteren;
    end

    // ---------------- legality ----------------
    assign counteren_word = counteren_reg;

    always_comb begin
        wr_intent = (bus.csr_op == CSR_OP_RW) ||
                    (((bus.csr_op == CSR_OP_RS) || (bus.csr_op == CSR_OP_RC)) && !bus.csr_rs1_zero);
        illegal = 1'b0;
        if (hit) begin
            if (wr_intent && (addr[11:10] == 2'b11)) illegal = 1'b1;
            if (addr[9:8] > bus.csr_priv)           illegal = 1'b1;
            // mcounteren bit n gates unprivileged counter n (HPM bits are 0)
            if (in_ucnt && (bus.csr_priv != PRIV_M) && !counteren_word[idx]) illegal = 1'b1;
        end
        do_write = bus.csr_req && hit && !illegal && wr_intent;
    end

    // ---------------- read mux ----------------
    always_comb begin
        case (idx)
            5'd0:    cnt_sel = mcycle;
            5'd1:    cnt_sel = mtime;     // only reachable via TIME/TIMEH
            5'd2:    cnt_sel = minstret;
            default: cnt_sel = 64'h0;
        endcase
        rd_val = 32'h0;
        if (in_mcnt || in_ucnt) begin
            rd_val = addr[7] ? cnt_sel[63:32] : cnt_sel[31:0];
        end else if (is_inhibit) begin
            rd_val = inhibit_reg;
        end else if (is_counteren) begin
            rd_val = counteren_reg;
        end
        wr_val = csr_apply_op(bus.csr_op, rd_val, bus.csr_wdata);
    end

    // ---------------- control registers ----------------
    always_comb begin
        inhibit_next   = inhibit_reg;
        counteren_next = counteren_reg;
        if (do_write && is_inhibit) begin
            inhibit_next    = '0;
            inhibit_next.cy = wr_val[INHIBIT_CY];
            inhibit_next.ir = wr_val[INHIBIT_IR];
        end
        if (do_write && is_counteren) begin
            counteren_next    = '0;
            counteren_next.cy = wr_val[COUNTEREN_CY];
            counteren_next.tm = wr_val[COUNTEREN_TM];
            counteren_next.ir = wr_val[COUNTEREN_IR];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inhibit_reg   <= '0;
            counteren_reg <= '0;
        end else begin
            inhibit_reg   <= inhibit_next;
            counteren_reg <= counteren_next;
        end
    end

    // ---------------- counters ----------------
    // Inhibit bits are taken from the register, so an mcountinhibit write
    // only affects counting from the following cycle.
    csr_counters_counter64 #(
        .INC_W   (1),
        .RST_VAL (MCYCLE_RST)
    ) u_mcycle (
        .clk     (clk),
        .rst     (rst),
        .inc     (1'b1),
        .inhibit (inhibit_reg.cy),
        .wr_lo   (do_write && in_mcnt_lo && (idx == 5'd0)),
        .wr_hi   (do_write && in_mcnt_hi && (idx == 5'd0)),
        .wdata   (wr_val),
        .value   (mcycle)
    );

    csr_counters_counter64 #(
        .INC_W   (RETIRE_W),
        .RST_VAL (MINSTRET_RST)
    ) u_minstret (
        .clk     (clk),
        .rst     (rst),
        .inc     (retire_count),
        .inhibit (inhibit_reg.ir),
        .wr_lo   (do_write && in_mcnt_lo && (idx == 5'd2)),
        .wr_hi   (do_write && in_mcnt_hi && (idx == 5'd2)),
        .wdata   (wr_val),
        .value   (minstret)
    );

    // ---------------- response stage ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_reg   <= 1'b0;
            rsp_hit_reg     <= 1'b0;
            rsp_illegal_reg <= 1'b0;
            rsp_rdata_reg   <= 32'h0;
        end else begin
            rsp_valid_reg   <= bus.csr_req;
            rsp_hit_reg     <= bus.csr_req && hit;
            rsp_illegal_reg <= bus.csr_req && hit && illegal;
            rsp_rdata_reg   <= (bus.csr_req && hit && !illegal) ? rd_val : 32'h0;
        end
    end

    assign bus.rsp_valid   = rsp_valid_reg;
    assign bus.rsp_hit     = rsp_hit_reg;
    assign bus.rsp_illegal = rsp_illegal_reg;
    assign bus.rsp_rdata   = rsp_rdata_reg;
endmodule

// File: tb/tb_csr_counters.sv
// ----------------------------------------------------------------------------
// tb_csr_counters
// Directed bench for csr_counters. Inputs change on the falling edge; each
// access holds csr_req for one rising edge and the response is sampled 1 ns
// after that edge. Expected values are hand-computed from the cycle count.
// ----------------------------------------------------------------------------
module tb_csr_counters;
    import csr_counters_pkg::*;

    logic        clk;
    logic        rst;
    logic [1:0]  retire_count;
    logic [63:0] mtime;

    csr_counters_if bus();

    csr_counters dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .retire_count (retire_count),
        .mtime        (mtime)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic        r_valid, r_hit, r_ill;
    logic [31:0] r_rdata;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One request cycle; leaves the bench on the next falling edge.
    task automatic csr_access(input csr_op_t op, input logic [11:0] addr,
                              input logic [31:0] wdata, input logic rs1z,
                              input logic [1:0] priv);
        bus.csr_req      = 1'b1;
        bus.csr_op       = op;
        bus.csr_addr     = addr;
        bus.csr_wdata    = wdata;
        bus.csr_rs1_zero = rs1z;
        bus.csr_priv     = priv;
        @(posedge clk);
        #1;
        r_valid = bus.rsp_valid;
        r_hit   = bus.rsp_hit;
        r_ill   = bus.rsp_illegal;
        r_rdata = bus.rsp_rdata;
        bus.csr_req = 1'b0;
        bus.csr_op  = CSR_OP_NONE;
        $display("txn op=%0d addr=%03h wdata=%08h priv=%0d -> valid=%0b hit=%0b illegal=%0b rdata=%08h",
                 op, addr, wdata, priv, r_valid, r_hit, r_ill, r_rdata);
        @(negedge clk);
    endtask

    task automatic csr_read(input logic [11:0] addr, input logic [1:0] priv);
        csr_access(CSR_OP_RS, addr, 32'h0, 1'b1, priv);
    endtask

    task automatic csr_write(input logic [11:0] addr, input logic [31:0] wdata);
        csr_access(CSR_OP_RW, addr, wdata, 1'b0, PRIV_M);
    endtask

    // Checks a completed response: valid, legality and read data.
    task automatic expect_rsp(input string tag, input logic ill, input logic [31:0] rdata);
        check({tag, ".valid"}, 64'(r_valid), 64'(1'b1));
        check({tag, ".illegal"}, 64'(r_ill), 64'(ill));
        check({tag, ".rdata"}, 64'(r_rdata), 64'(rdata));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst              = 1'b1;
        retire_count     = 2'd0;
        mtime            = 64'h1234_5678_9ABC_DEF0;
        bus.csr_req      = 1'b0;
        bus.csr_op       = CSR_OP_NONE;
        bus.csr_addr     = 12'h0;
        bus.csr_wdata    = 32'h0;
        bus.csr_rs1_zero = 1'b1;
        bus.csr_priv     = PRIV_M;

        // Reset state
        idle(3);
        check("rst.valid",   64'(bus.rsp_valid),   64'd0);
        check("rst.hit",     64'(bus.rsp_hit),     64'd0);
        check("rst.illegal", 64'(bus.rsp_illegal), 64'd0);
        check("rst.rdata",   64'(bus.rsp_rdata),   64'd0);
        rst = 1'b0;

        // 10 idle cycles then read MCYCLE -> 10
        idle(10);
        check("pre.valid", 64'(bus.rsp_valid), 64'd0);
        csr_read(CSR_MCYCLE, PRIV_M);                // mcycle -> 11
        expect_rsp("mcycle10", 1'b0, 32'd10);
        check("mcycle10.hit", 64'(r_hit), 64'd1);
        idle(1);                                     // mcycle -> 12
        check("idle.valid", 64'(bus.rsp_valid), 64'd0);

        // Carry across halves
        csr_write(CSR_MCYCLE, 32'hFFFF_FFFF);        // returns pre-write 12
        expect_rsp("wr_mcycle", 1'b0, 32'd12);
        csr_write(CSR_MCYCLEH, 32'h0);               // {0,FFFFFFFF}, no increment
        expect_rsp("wr_mcycleh", 1'b0, 32'd0);
        idle(1);                                     // {1,0}
        csr_read(CSR_MCYCLEH, PRIV_M);               // -> {1,1}
        expect_rsp("carry_hi", 1'b0, 32'd1);
        csr_read(CSR_MCYCLE, PRIV_M);                // -> {1,2}
        expect_rsp("carry_lo", 1'b0, 32'd1);

        // minstret write beats the increment
        retire_count = 2'd2;
        csr_write(CSR_MINSTRET, 32'd5);              // mcycle {1,3}
        expect_rsp("wr_minstret", 1'b0, 32'd0);
        csr_read(CSR_MINSTRET, PRIV_M);              // -> 7, mcycle {1,4}
        expect_rsp("minstret5", 1'b0, 32'd5);
        retire_count = 2'd0;
        csr_read(CSR_MINSTRET, PRIV_M);              // mcycle {1,5}
        expect_rsp("minstret7", 1'b0, 32'd7);
        csr_read(CSR_MINSTRETH, PRIV_M);             // mcycle {1,6}
        expect_rsp("minstreth", 1'b0, 32'd0);

        // Inhibit: write cycle still counts (mcycle {1,7}), then frozen
        csr_access(CSR_OP_RS, CSR_MCOUNTINHIBIT, 32'hFFFF_FFFF, 1'b0, PRIV_M);
        expect_rsp("rs_inhibit", 1'b0, 32'd0);
        csr_read(CSR_MCOUNTINHIBIT, PRIV_M);
        expect_rsp("inhibit_rd", 1'b0, 32'h5);
        csr_read(CSR_MCYCLE, PRIV_M);
        expect_rsp("frozen0", 1'b0, 32'd7);
        retire_count = 2'd2;
        idle(20);
        retire_count = 2'd0;
        csr_read(CSR_MCYCLE, PRIV_M);
        expect_rsp("frozen20", 1'b0, 32'd7);
        csr_read(CSR_MINSTRET, PRIV_M);
        expect_rsp("frozen_ir", 1'b0, 32'd7);
        csr_access(CSR_OP_RC, CSR_MCOUNTINHIBIT, 32'h1, 1'b0, PRIV_M);  // still frozen this cycle
        expect_rsp("rc_inhibit", 1'b0, 32'h5);
        csr_read(CSR_MCYCLE, PRIV_M);                // -> 8
        expect_rsp("resume0", 1'b0, 32'd7);
        csr_read(CSR_MCYCLE, PRIV_M);                // -> 9
        expect_rsp("resume1", 1'b0, 32'd8);
        csr_read(CSR_MCOUNTINHIBIT, PRIV_M);         // -> 10
        expect_rsp("inhibit_ir", 1'b0, 32'h4);

        // 64-bit wrap
        csr_write(CSR_MCYCLEH, 32'hFFFF_FFFF);       // lo stays 10
        expect_rsp("wr_h_ff", 1'b0, 32'd1);
        csr_write(CSR_MCYCLE, 32'hFFFF_FFFF);
        expect_rsp("wr_l_ff", 1'b0, 32'd10);
        csr_read(CSR_MCYCLE, PRIV_M);                // wraps to {0,0}
        expect_rsp("wrap_lo", 1'b0, 32'hFFFF_FFFF);
        csr_read(CSR_MCYCLEH, PRIV_M);               // -> {0,1}
        expect_rsp("wrap_hi", 1'b0, 32'd0);
        csr_read(CSR_MCYCLE, PRIV_M);                // -> {0,2}
        expect_rsp("wrap_lo1", 1'b0, 32'd1);

        // Privilege and mcounteren
        csr_read(CSR_CYCLE, PRIV_U);                 // -> 3
        expect_rsp("u_cycle_off", 1'b1, 32'd0);
        check("u_cycle_off.hit", 64'(r_hit), 64'd1);
        csr_write(CSR_MCOUNTEREN, 32'h1);            // -> 4
        expect_rsp("wr_cnten", 1'b0, 32'd0);
        csr_read(CSR_CYCLE, PRIV_U);                 // -> 5
        expect_rsp("u_cycle_on", 1'b0, 32'd4);
        csr_read(CSR_TIME, PRIV_U);                  // -> 6
        expect_rsp("u_time_off", 1'b1, 32'd0);
        csr_read(CSR_TIMEH, PRIV_M);                 // -> 7
        expect_rsp("m_timeh", 1'b0, 32'h1234_5678);
        csr_read(CSR_TIME, PRIV_M);                  // -> 8
        expect_rsp("m_time", 1'b0, 32'h9ABC_DEF0);
        csr_write(CSR_CYCLE, 32'h55);                // read-only -> 9
        expect_rsp("rw_cycle", 1'b1, 32'd0);
        csr_access(CSR_OP_RS, CSR_CYCLE, 32'h0, 1'b1, PRIV_M);  // -> 10
        expect_rsp("rs0_cycle", 1'b0, 32'd9);
        csr_read(CSR_INSTRET, PRIV_S);
        expect_rsp("s_instret", 1'b1, 32'd0);
        csr_read(CSR_MCYCLE, PRIV_U);
        expect_rsp("u_mcycle", 1'b1, 32'd0);
        csr_read(CSR_MCOUNTEREN, PRIV_S);
        expect_rsp("s_cnten", 1'b1, 32'd0);
        csr_write(CSR_MCOUNTEREN, 32'hFFFF_FFFF);
        csr_read(CSR_MCOUNTEREN, PRIV_M);
        expect_rsp("cnten_mask", 1'b0, 32'h7);

        // HPM range and misses
        csr_write(CSR_MHPMCOUNTER3, 32'd123);
        expect_rsp("wr_hpm3", 1'b0, 32'd0);
        check("wr_hpm3.hit", 64'(r_hit), 64'd1);
        csr_read(CSR_MHPMCOUNTER3, PRIV_M);
        expect_rsp("rd_hpm3", 1'b0, 32'd0);
        csr_write(CSR_MHPMEVENT3, 32'h77);
        expect_rsp("wr_evt3", 1'b0, 32'd0);
        csr_write(12'h7C0, 32'h1);
        expect_rsp("miss", 1'b0, 32'd0);
        check("miss.hit", 64'(r_hit), 64'd0);

        // Reset in the middle of a request
        bus.csr_req      = 1'b1;
        bus.csr_op       = CSR_OP_RS;
        bus.csr_addr     = CSR_MCYCLE;
        bus.csr_rs1_zero = 1'b1;
        bus.csr_priv     = PRIV_M;
        #2 rst = 1'b1;
        @(negedge clk);
        bus.csr_req = 1'b0;
        rst = 1'b0;
        check("midrst.valid", 64'(bus.rsp_valid), 64'd0);
        csr_read(CSR_MCYCLE, PRIV_M);
        expect_rsp("post_rst_mcycle", 1'b0, 32'd0);
        csr_read(CSR_MCOUNTEREN, PRIV_M);
        expect_rsp("post_rst_cnten", 1'b0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
